// File: rtl/aes_prng_reseed_ctrl_if.sv
// Signal bundle between the PRNG reseed controller and its environment
// (AES control FSM, clearing PRNG, status CSR).
interface aes_prng_reseed_ctrl_if #(
   parameter int CntW = 16
);
   logic [1:0]      rate;
   logic            block_done;
   logic            sw_reseed;
   logic            reseed_req;
   logic            reseed_ack;
   logic            stall;
   logic            reseed_done;
   logic [CntW-1:0] blk_cnt;
   logic            err_timeout;

   modport master (
      input  rate, block_done, sw_reseed, reseed_ack,
      output reseed_req, stall, reseed_done, blk_cnt, err_timeout
   );

   modport slave (
      output rate, block_done, sw_reseed, reseed_ack,
      input  reseed_req, stall, reseed_done, blk_cnt, err_timeout
   );
endinterface

// File: rtl/aes_prng_reseed_ctrl.sv
// Decides when the clearing PRNG is reseeded: block-count threshold or software trigger.
// Optional reseed watchdog enabled by macro AES_RESEED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | counting blocks, evaluating triggers
// REQ   | reseed requested, waiting for PRNG ack, PRNG data requests stalled
// DONE  | one-cycle reseed-complete pulse
module aes_prng_reseed_ctrl #(
   parameter int CntW          = 16,
   parameter int TimeoutCycles = 1024
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   aes_prng_reseed_ctrl_if.master bus
);

   if (CntW < 14) begin : g_chk_cntw
      $error("CntW must be at least 14 to hold the 8192 threshold");
   end
   if (TimeoutCycles < 2) begin : g_chk_timeout
      $error("TimeoutCycles must be at least 2");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d, cnt_nxt;
   logic [CntW-1:0] thr;
   logic            pend_q, pend_d;
   logic            trig;

   assign cnt_nxt = (bus.block_done && (cnt_q != {CntW{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

   always_comb begin
      thr = CntW'(8192);
      case (bus.rate)
         2'b00:   thr = CntW'(1);
         2'b01:   thr = CntW'(64);
         default: thr = CntW'(8192);
      endcase
   end

   // pend_q carries a software trigger that arrived during DONE into IDLE
   assign trig = bus.sw_reseed || pend_q || ((bus.rate != 2'b11) && (cnt_nxt >= thr));

`ifdef AES_RESEED_TIMEOUT_EN
   localparam int WdW = $clog2(TimeoutCycles);
   localparam logic [WdW-1:0] WdLoad = WdW'(TimeoutCycles - 1);

   logic [WdW-1:0] wd_q, wd_d;
   logic           err_q, err_d;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
`ifdef AES_RESEED_TIMEOUT_EN
         wd_q    <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
`ifdef AES_RESEED_TIMEOUT_EN
         wd_q    <= wd_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_nxt;
      pend_d  = pend_q;
`ifdef AES_RESEED_TIMEOUT_EN
      wd_d    = wd_q;
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (trig) begin
               state_d = REQ;
               cnt_d   = '0;
               pend_d  = 1'b0;
`ifdef AES_RESEED_TIMEOUT_EN
               wd_d    = WdLoad;
`endif
            end
         end
         REQ: begin
            if (bus.reseed_ack) begin
               state_d = DONE;
            end
`ifdef AES_RESEED_TIMEOUT_EN
            else if (wd_q == '0) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q - 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
            if (bus.sw_reseed) pend_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.reseed_req  = (state_q == REQ);
   assign bus.stall       = (state_q == REQ);
   assign bus.reseed_done = (state_q == DONE);
   assign bus.blk_cnt     = cnt_q;
`ifdef AES_RESEED_TIMEOUT_EN
   assign bus.err_timeout = err_q;
`else
   assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_aes_prng_reseed_ctrl.sv
// Self-checking bench for aes_prng_reseed_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural model.
module tb_aes_prng_reseed_ctrl;

   localparam int CntW = 16;
   localparam int TO   = 16;
`ifdef AES_RESEED_TIMEOUT_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   aes_prng_reseed_ctrl_if #(.CntW(CntW)) bus ();

   aes_prng_reseed_ctrl #(.CntW(CntW), .TimeoutCycles(TO)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [1:0] rate;
      bit         bd, sw, ack;
      bit         req, stall, done;
      int         cnt;
   } vec_t;

   vec_t tbl[20];

   // behavioural model
   int m_cnt, m_age;
   bit m_req, m_done, m_err, m_carry;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input logic [1:0] r, input bit bd, input bit sw, input bit ack);
      bus.rate       = r;
      bus.block_done = bd;
      bus.sw_reseed  = sw;
      bus.reseed_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_cnt = 0; m_age = 0; m_req = 0; m_done = 0; m_err = 0; m_carry = 0;
   endtask

   task automatic model_step(input logic [1:0] r, input bit bd, input bit sw, input bit ack);
      int nc, thr;
      nc  = (bd && m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      thr = (r == 0) ? 1 : (r == 1) ? 64 : (r == 2) ? 8192 : 32'h4000_0000;
      if (m_req) begin
         m_age++;
         if (ack) begin
            m_req = 0; m_done = 1;
         end else if (WD_EN && m_age >= TO) begin
            m_req = 0; m_err = 1;
         end
         m_cnt = nc;
      end else if (m_done) begin
         m_done = 0; m_carry = sw; m_cnt = nc;
      end else if (sw || m_carry || nc >= thr) begin
         m_req = 1; m_age = 0; m_cnt = 0; m_carry = 0;
      end else begin
         m_cnt = nc;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.rate = 2'b11; bus.block_done = 0; bus.sw_reseed = 0; bus.reseed_ack = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {bus.reseed_req, bus.stall, bus.reseed_done, bus.err_timeout, bus.blk_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int hi;
      bit early;
      logic [1:0] r;
      bit bd, sw, ack;

      tbl[0]  = '{2'd3, 1, 0, 0, 0, 0, 0, 1};
      tbl[1]  = '{2'd3, 1, 0, 0, 0, 0, 0, 2};
      tbl[2]  = '{2'd3, 0, 0, 1, 0, 0, 0, 2};
      tbl[3]  = '{2'd3, 0, 1, 0, 1, 1, 0, 0};
      tbl[4]  = '{2'd3, 1, 1, 0, 1, 1, 0, 1};
      tbl[5]  = '{2'd3, 0, 0, 1, 0, 0, 1, 1};
      tbl[6]  = '{2'd1, 0, 0, 0, 0, 0, 0, 1};
      tbl[7]  = '{2'd0, 0, 0, 0, 1, 1, 0, 0};
      tbl[8]  = '{2'd0, 1, 0, 1, 0, 0, 1, 1};
      tbl[9]  = '{2'd3, 0, 0, 0, 0, 0, 0, 1};
      tbl[10] = '{2'd0, 1, 1, 0, 1, 1, 0, 0};
      tbl[11] = '{2'd0, 0, 0, 1, 0, 0, 1, 0};
      tbl[12] = '{2'd3, 0, 0, 0, 0, 0, 0, 0};
      tbl[13] = '{2'd3, 0, 0, 0, 0, 0, 0, 0};
      tbl[14] = '{2'd3, 0, 1, 0, 1, 1, 0, 0};
      tbl[15] = '{2'd3, 0, 0, 1, 0, 0, 1, 0};
      tbl[16] = '{2'd3, 0, 1, 0, 0, 0, 0, 0};
      tbl[17] = '{2'd3, 0, 0, 0, 1, 1, 0, 0};
      tbl[18] = '{2'd3, 0, 0, 1, 0, 0, 1, 0};
      tbl[19] = '{2'd3, 0, 0, 0, 0, 0, 0, 0};

      do_reset();
      for (int i = 0; i < 20; i++) begin
         apply(tbl[i].rate, tbl[i].bd, tbl[i].sw, tbl[i].ack);
         chk($sformatf("vec%0d", i),
             {13'h0, bus.reseed_req, bus.stall, bus.reseed_done, bus.blk_cnt},
             {13'h0, tbl[i].req, tbl[i].stall, tbl[i].done, tbl[i].cnt[15:0]});
      end

      // rate 64: request exactly after the 64th block
      do_reset();
      early = 0;
      for (int i = 0; i < 64; i++) begin
         apply(2'd1, 1, 0, 0);
         if (i < 63 && bus.reseed_req) early = 1;
      end
      chk("rate64_early", {31'h0, early}, 32'h0);
      chk("rate64_req", {15'h0, bus.reseed_req, bus.blk_cnt}, 32'h0001_0000);
      apply(2'd1, 0, 0, 1);
      chk("rate64_done", {30'h0, bus.reseed_done, bus.reseed_req}, 32'h2);

      // software trigger, ack in 5th request cycle
      do_reset();
      apply(2'd3, 0, 1, 0);
      hi = 0;
      for (int k = 0; k < 5; k++) begin
         hi += int'(bus.reseed_req);
         apply(2'd3, 0, 0, (k == 4));
      end
      chk("sw_req_cycles", hi, 5);
      chk("sw_done", {29'h0, bus.reseed_done, bus.stall, bus.reseed_req}, 32'h4);
      apply(2'd3, 0, 0, 0);
      chk("sw_done_once", {31'h0, bus.reseed_done}, 32'h0);

      // blocks and a merged sw trigger during REQ
      do_reset();
      apply(2'd3, 0, 1, 0);
      apply(2'd3, 1, 0, 0);
      apply(2'd3, 1, 0, 0);
      apply(2'd3, 1, 1, 0);
      chk("ovl_stall", {31'h0, bus.stall}, 32'h1);
      apply(2'd3, 0, 0, 1);
      chk("ovl_done", {15'h0, bus.reseed_done, bus.blk_cnt}, 32'h0001_0003);
      early = 0;
      for (int k = 0; k < 4; k++) begin
         apply(2'd3, 0, 0, 0);
         if (bus.reseed_req || bus.reseed_done) early = 1;
      end
      chk("ovl_no_second", {31'h0, early}, 32'h0);
      chk("ovl_cnt", {16'h0, bus.blk_cnt}, 32'd3);

      // lowering the rate mid-count
      do_reset();
      for (int i = 0; i < 100; i++) apply(2'd2, 1, 0, 0);
      chk("rchg_cnt", {15'h0, bus.reseed_req, bus.blk_cnt}, 32'd100);
      apply(2'd1, 0, 0, 0);
      chk("rchg_req", {15'h0, bus.reseed_req, bus.blk_cnt}, 32'h0001_0000);

      // asynchronous reset while in REQ
      do_reset();
      apply(2'd3, 0, 1, 0);
      apply(2'd3, 1, 0, 0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("rst_async", {bus.reseed_req, bus.stall, bus.reseed_done, bus.err_timeout, bus.blk_cnt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      apply(2'd3, 0, 0, 0);
      chk("rst_after", {12'h0, bus.reseed_req, bus.reseed_done, bus.stall, bus.err_timeout, bus.blk_cnt}, 32'h0);

      // watchdog: no ack for TO request cycles
      do_reset();
      apply(2'd3, 0, 1, 0);
      early = 0;
      for (int k = 0; k < TO - 1; k++) begin
         apply(2'd3, 0, 0, 0);
         if (!bus.reseed_req || bus.err_timeout) early = 1;
      end
      chk("wd_hold", {31'h0, early}, 32'h0);
      apply(2'd3, 0, 0, 0);
      chk("wd_expire", {29'h0, bus.reseed_req, bus.err_timeout, bus.reseed_done},
          WD_EN ? 32'h2 : 32'h4);
      apply(2'd3, 0, 0, 1);
      apply(2'd3, 0, 0, 0);
      chk("wd_sticky", {31'h0, bus.err_timeout}, {31'h0, WD_EN});

      // randomized traffic against the model
      do_reset();
      r = 2'd1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) r = 2'($urandom_range(0, 3));
         bd  = ($urandom_range(0, 2) == 0);
         sw  = ($urandom_range(0, 29) == 0);
         ack = ($urandom_range(0, 4) == 0);
         model_step(r, bd, sw, ack);
         apply(r, bd, sw, ack);
         chk($sformatf("rand%0d", c),
             {12'h0, bus.reseed_req, bus.stall, bus.reseed_done, bus.err_timeout, bus.blk_cnt},
             {12'h0, m_req, m_req, m_done, m_err, m_cnt[15:0]});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
